// File: rtl/ex_wb_if.sv
// ex_wb_if: bundles the EX->WB stage signals.
//   master side (execute / operand-fetch / control) drives the EX results,
//   control, stall/flush and the operand-fetch source addresses.
//   slave side (ex_wb_stage) drives the register-file write port, the
//   forwarding hits, the sticky flags and the retired-instruction counter.
interface ex_wb_if #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
);
    logic          stall;
    logic          flush;
    logic          RW_EX;
    logic [AW-1:0] DA_EX;
    logic [1:0]    MD_EX;
    logic [DW-1:0] F;
    logic [DW-1:0] Data_out;
    logic          NxorV;
    logic          C;
    logic          V;
    logic          N;
    logic          Z;
    logic [AW-1:0] src_a;
    logic [AW-1:0] src_b;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          fwd_a_hit;
    logic          fwd_b_hit;
    logic [3:0]    flags;
    logic [CW-1:0] retired;

    modport master (
        output stall, flush, RW_EX, DA_EX, MD_EX, F, Data_out,
               NxorV, C, V, N, Z, src_a, src_b,
        input  wr_en, wr_addr, wr_data, fwd_a_hit, fwd_b_hit, flags, retired
    );

    modport slave (
        input  stall, flush, RW_EX, DA_EX, MD_EX, F, Data_out,
               NxorV, C, V, N, Z, src_a, src_b,
        output wr_en, wr_addr, wr_data, fwd_a_hit, fwd_b_hit, flags, retired
    );
endinterface

// File: rtl/ex_wb_stage.sv
// ex_wb_stage: EX/WB pipeline register plus writeback mux.
//   clk  - rising-edge clock
//   rst  - synchronous active-high reset (priority over flush and stall)
//   bus  - ex_wb_if.slave: EX results/control in, register-file write port,
//          forwarding hits, sticky {C,V,N,Z} flags and retired counter out.
module ex_wb_stage #(
    parameter int DW = 32,
    parameter int AW = 5,
    parameter int CW = 32
) (
    input  logic      clk,
    input  logic      rst,
    ex_wb_if.slave    bus
);
    logic          valid;
    logic          rw_q;
    logic [AW-1:0] da_q;
    logic [1:0]    md_q;
    logic [DW-1:0] f_q;
    logic [DW-1:0] d_q;
    logic          nv_q;
    logic [3:0]    flags_q;
    logic [CW-1:0] retired_q;

    // The entry leaves the stage when it is replaced: either by a normal
    // load or by a flush bubble (flush overrides stall).
    logic advance;
    assign advance = bus.flush | ~bus.stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            valid     <= 1'b0;
            rw_q      <= 1'b0;
            da_q      <= '0;
            md_q      <= 2'b00;
            f_q       <= '0;
            d_q       <= '0;
            nv_q      <= 1'b0;
            flags_q   <= 4'b0000;
            retired_q <= '0;
        end else begin
            if (valid && advance)
                retired_q <= retired_q + 1'b1;
            if (bus.flush) begin
                // Data fields hold; only the qualifiers are cleared.
                valid <= 1'b0;
                rw_q  <= 1'b0;
            end else if (!bus.stall) begin
                valid   <= 1'b1;
                rw_q    <= bus.RW_EX;
                da_q    <= bus.DA_EX;
                md_q    <= bus.MD_EX;
                f_q     <= bus.F;
                d_q     <= bus.Data_out;
                nv_q    <= bus.NxorV;
                flags_q <= {bus.C, bus.V, bus.N, bus.Z};
            end
        end
    end

    logic [DW-1:0] wb_val;
    always_comb begin
        wb_val = f_q;
        case (md_q)
            2'b01:   wb_val = d_q;
            2'b10:   wb_val = {{(DW-1){1'b0}}, nv_q};
            default: wb_val = f_q;  // 11 is reserved and behaves as 00
        endcase
    end

    // R0 is hard-wired zero, so writes to it are dropped; this also keeps
    // a zero source address from ever matching for forwarding.
    logic we;
    assign we = valid & rw_q & (da_q != '0);

    assign bus.wr_en     = we;
    assign bus.wr_addr   = da_q;
    assign bus.wr_data   = wb_val;
    assign bus.fwd_a_hit = we & (bus.src_a == da_q);
    assign bus.fwd_b_hit = we & (bus.src_b == da_q);
    assign bus.flags     = flags_q;
    assign bus.retired   = retired_q;
endmodule

// File: tb/tb_ex_wb_stage.sv
module tb_ex_wb_stage;
    localparam int DW = 32;
    localparam int AW = 5;
    localparam int CW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_wb_if #(.DW(DW), .AW(AW), .CW(CW)) bus ();

    ex_wb_stage #(.DW(DW), .AW(AW), .CW(CW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;
    bit chk_en   = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the instruction currently sitting in writeback.
    bit          m_valid = 0, m_rw = 0, m_nv = 0;
    int unsigned m_da = 0, m_md = 0, m_f = 0, m_d = 0;
    int unsigned m_flags = 0, m_ret = 0;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 0; m_rw = 0; m_nv = 0;
            m_da = 0; m_md = 0; m_f = 0; m_d = 0;
            m_flags = 0; m_ret = 0;
        end else begin
            if (m_valid && (bus.flush || !bus.stall))
                m_ret = (m_ret + 1) % 16;
            if (bus.flush) begin
                m_valid = 0; m_rw = 0;
            end else if (!bus.stall) begin
                m_valid = 1;
                m_rw    = bus.RW_EX;
                m_da    = bus.DA_EX;
                m_md    = bus.MD_EX;
                m_f     = bus.F;
                m_d     = bus.Data_out;
                m_nv    = bus.NxorV;
                m_flags = bus.C * 8 + bus.V * 4 + bus.N * 2 + bus.Z;
            end
        end
    end

    function automatic int unsigned exp_data();
        if (m_md == 1) return m_d;
        if (m_md == 2) return m_nv ? 1 : 0;
        return m_f;
    endfunction

    function automatic bit exp_we();
        return m_valid && m_rw && (m_da != 0);
    endfunction

    always @(negedge clk) begin
        if (chk_en) begin
            chk("wr_en",   32'(bus.wr_en),   32'(exp_we()));
            chk("wr_addr", 32'(bus.wr_addr), m_da);
            chk("wr_data", bus.wr_data,      exp_data());
            chk("fwd_a",   32'(bus.fwd_a_hit), 32'(exp_we() && (bus.src_a == m_da)));
            chk("fwd_b",   32'(bus.fwd_b_hit), 32'(exp_we() && (bus.src_b == m_da)));
            chk("flags",   32'(bus.flags),   m_flags);
            chk("retired", 32'(bus.retired), m_ret);
        end
    end

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        #1;
    endtask

    task automatic idle();
        bus.stall = 0; bus.flush = 0; bus.RW_EX = 0; bus.DA_EX = '0;
        bus.MD_EX = 2'b00; bus.F = '0; bus.Data_out = '0; bus.NxorV = 0;
        bus.C = 0; bus.V = 0; bus.N = 0; bus.Z = 0;
        bus.src_a = '0; bus.src_b = '0;
    endtask

    task automatic instr(input int da, input int md, input logic [31:0] f,
                         input logic [31:0] d, input bit nv);
        idle();
        bus.RW_EX = 1; bus.DA_EX = AW'(da); bus.MD_EX = 2'(md);
        bus.F = f; bus.Data_out = d; bus.NxorV = nv;
    endtask

    int unsigned r0;

    initial begin
        idle();
        // 1. reset with a write request on the inputs
        rst = 1; bus.RW_EX = 1; bus.DA_EX = 5'd3;
        tick(); tick();
        chk("rst_wr_en", 32'(bus.wr_en), 0);
        chk("rst_wr_data", bus.wr_data, 0);
        chk("rst_flags", 32'(bus.flags), 0);
        chk("rst_retired", 32'(bus.retired), 0);
        idle(); rst = 0;
        chk_en = 1;
        tick();  // release edge loads a null non-writing instruction (counted later)

        // 2. ALU writeback and forwarding
        instr(5, 0, 32'h0000_1234, 32'h0, 0);
        tick();
        bus.src_a = 5'd5; bus.src_b = 5'd6; bus.flush = 1;
        #1;
        chk("alu_wr_en", 32'(bus.wr_en), 1);
        chk("alu_wr_addr", 32'(bus.wr_addr), 5);
        chk("alu_wr_data", bus.wr_data, 32'h1234);
        chk("alu_fwd_a", 32'(bus.fwd_a_hit), 1);
        chk("alu_fwd_b", 32'(bus.fwd_b_hit), 0);
        tick();
        chk("alu_retired", 32'(bus.retired), 2);

        // 3. load and set-less-than
        instr(7, 1, 32'h5555_5555, 32'hDEAD_BEEF, 0);
        tick();
        chk("load_data", bus.wr_data, 32'hDEAD_BEEF);
        instr(8, 2, 32'h5555_5555, 32'hDEAD_BEEF, 1);
        tick();
        chk("slt_data", bus.wr_data, 32'h0000_0001);

        // 4. R0 and RW=0 suppression
        instr(0, 0, 32'hFFFF_FFFF, 32'h0, 0);
        bus.src_a = '0;
        tick();
        chk("r0_wr_en", 32'(bus.wr_en), 0);
        chk("r0_fwd_a", 32'(bus.fwd_a_hit), 0);
        instr(4, 0, 32'h0000_0044, 32'h0, 0);
        bus.RW_EX = 0;
        tick();
        chk("rw0_wr_en", 32'(bus.wr_en), 0);
        chk("rw0_retired", 32'(bus.retired), 5);

        // 5. stall holds, flush overrides stall
        instr(9, 0, 32'h0000_0099, 32'h0, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            instr($urandom_range(1, 31), $urandom_range(0, 3), $urandom, $urandom, 1);
            bus.stall = 1;
            tick();
            chk("stall_addr", 32'(bus.wr_addr), 9);
            chk("stall_data", bus.wr_data, 32'h99);
            chk("stall_we", 32'(bus.wr_en), 1);
        end
        r0 = m_ret;
        bus.stall = 1; bus.flush = 1;
        tick();
        chk("flush_we", 32'(bus.wr_en), 0);
        chk("flush_retired", 32'(bus.retired), (r0 + 1) % 16);

        // 6. counter wrap and sticky flags
        idle(); rst = 1;
        tick();
        rst = 0;
        for (int i = 0; i < 16; i++) begin
            instr(1 + (i % 31), 0, 32'(i), 32'h0, 0);
            if (i == 15) begin bus.C = 1; bus.V = 0; bus.N = 1; bus.Z = 0; end
            tick();
        end
        chk("wrap_15", 32'(bus.retired), 15);
        idle(); bus.flush = 1;
        tick();
        chk("wrap_0", 32'(bus.retired), 0);
        tick();
        chk("flags_sticky", 32'(bus.flags), 32'b1010);

        // randomized traffic against the model
        for (int i = 0; i < 400; i++) begin
            idle();
            rst          = ($urandom_range(0, 49) == 0);
            bus.flush    = ($urandom_range(0, 7) == 0);
            bus.stall    = ($urandom_range(0, 3) == 0);
            bus.RW_EX    = ($urandom_range(0, 3) != 0);
            bus.DA_EX    = AW'($urandom_range(0, 7));
            bus.MD_EX    = 2'($urandom_range(0, 3));
            bus.F        = $urandom;
            bus.Data_out = $urandom;
            bus.NxorV    = 1'($urandom);
            {bus.C, bus.V, bus.N, bus.Z} = 4'($urandom);
            bus.src_a    = AW'($urandom_range(0, 7));
            bus.src_b    = AW'($urandom_range(0, 7));
            tick();
        end
        rst = 0;
        chk_en = 0;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
